// File: rtl/sigmoid_term_gen_if.sv
// Stream interface for the sigmoid term generator: x input channel and A/B/C term output channel.
interface sigmoid_term_gen_if #(
    parameter int DWIDTH = 32
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DWIDTH-1:0] x_in;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [DWIDTH-1:0] term_a;
    logic signed [DWIDTH-1:0] term_b;
    logic signed [DWIDTH-1:0] term_c;

    modport slave (
        input  in_valid, x_in, out_ready,
        output in_ready, out_valid, term_a, term_b, term_c
    );

    modport master (
        output in_valid, x_in, out_ready,
        input  in_ready, out_valid, term_a, term_b, term_c
    );
endinterface

// File: rtl/sigmoid_term_gen.sv
// Three-stage pipeline producing piecewise-quadratic sigmoid terms A=c0, B=c1*|x|, C=c2*x^2.
// Build option: SIGMOID_TERM_ROUND_EN selects round-half-up rescaling instead of truncation.
module sigmoid_term_gen #(
    parameter int DWIDTH = 32,
    parameter int FRAC   = 24
) (
    input  logic              clk,
    input  logic              rst,
    sigmoid_term_gen_if.slave bus
);
    localparam int PW = 2 * DWIDTH;
    typedef logic signed [DWIDTH-1:0] word_t;
    typedef logic signed [PW-1:0]     wide_t;

    localparam word_t ONE = word_t'(1 << FRAC);
`ifdef SIGMOID_TERM_ROUND_EN
    localparam wide_t RND = wide_t'(1) << (FRAC - 1);
`else
    localparam wide_t RND = '0;
`endif

    // Per-unit-segment quadratic fit over |x| in [0,8), Q8.24; seg0 c0 pinned to 0.5.
    localparam word_t C0_ROM [8] = '{32'sd8388608, 32'sd8189849, 32'sd9366502, 32'sd11766566,
                                     32'sd13902306, 32'sd15278122, 32'sd16040142, 32'sd16431220};
    localparam word_t C1_ROM [8] = '{32'sd4341558, 32'sd4856836, 32'sd3706205, 32'sd2088294,
                                     32'sd1006348, 32'sd449496, 32'sd192837, 32'sd80128};
    localparam word_t C2_ROM [8] = '{-32'sd465031, -32'sd781550, -32'sd500397, -32'sd227768,
                                     -32'sd90765, -32'sd34427, -32'sd12818, -32'sd4698};

    function automatic word_t mul_rescale(input word_t a, input word_t b);
        wide_t full;
        full = PW'(a) * PW'(b) + RND;
        return word_t'(full >>> FRAC);
    endfunction

    logic       r_v1, r_v2, r_v3;
    logic       r_neg1, r_sat1, r_neg2, r_sat2;
    logic [2:0] r_seg1;
    word_t      r_ax1, r_c0_2, r_c2_2, r_p1_2, r_x2_2;
    word_t      r_term_a, r_term_b, r_term_c;

    logic  w_adv, w_neg, w_sat;
    word_t w_abs, w_ax, w_p1, w_x2, w_p2;
    word_t w_a, w_b, w_c;

    assign w_adv        = !r_v3 || bus.out_ready;
    assign bus.in_ready = w_adv && !rst;

    // Most-negative input overflows the abs, so it is caught explicitly as well.
    assign w_neg = bus.x_in[DWIDTH-1];
    assign w_abs = w_neg ? -bus.x_in : bus.x_in;
    assign w_sat = (|w_abs[DWIDTH-1:FRAC+3]) || (bus.x_in == {1'b1, {(DWIDTH-1){1'b0}}});
    assign w_ax  = w_sat ? '0 : w_abs;

    assign w_p1 = mul_rescale(C1_ROM[r_seg1], r_ax1);
    assign w_x2 = mul_rescale(r_ax1, r_ax1);
    assign w_p2 = mul_rescale(r_c2_2, r_x2_2);

    always_comb begin
        w_a = r_c0_2;
        w_b = r_p1_2;
        w_c = w_p2;
        if (r_sat2) begin
            w_a = r_neg2 ? '0 : ONE;
            w_b = '0;
            w_c = '0;
        end else if (r_neg2) begin
            w_a = ONE - r_c0_2;
            w_b = -r_p1_2;
            w_c = -w_p2;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_v2     <= 1'b0;
            r_v3     <= 1'b0;
            r_neg1   <= 1'b0;
            r_sat1   <= 1'b0;
            r_seg1   <= '0;
            r_ax1    <= '0;
            r_neg2   <= 1'b0;
            r_sat2   <= 1'b0;
            r_c0_2   <= '0;
            r_c2_2   <= '0;
            r_p1_2   <= '0;
            r_x2_2   <= '0;
            r_term_a <= '0;
            r_term_b <= '0;
            r_term_c <= '0;
        end else if (w_adv) begin
            r_v1     <= bus.in_valid;
            r_neg1   <= w_neg;
            r_sat1   <= w_sat;
            r_seg1   <= w_ax[FRAC+2:FRAC];
            r_ax1    <= w_ax;
            r_v2     <= r_v1;
            r_neg2   <= r_neg1;
            r_sat2   <= r_sat1;
            r_c0_2   <= C0_ROM[r_seg1];
            r_c2_2   <= C2_ROM[r_seg1];
            r_p1_2   <= w_p1;
            r_x2_2   <= w_x2;
            r_v3     <= r_v2;
            r_term_a <= w_a;
            r_term_b <= w_b;
            r_term_c <= w_c;
        end
    end

    assign bus.out_valid = r_v3;
    assign bus.term_a    = r_term_a;
    assign bus.term_b    = r_term_b;
    assign bus.term_c    = r_term_c;
endmodule
